mv_pwm_driver: RTL and testbench

Downstream consumer of the PID core's 32-bit signed manipulation value (MV) and its 5-bit overflow vector. The block scales and saturates each MV sample to an unsigned PWM duty and double-buffers it so duty changes only at period boundaries. It generates the actuator PWM waveform and trips a latched fault after a run of overflow-flagged samples.

---
 rtl/mv_pwm_driver.sv | 158 +++++++++++++++
 tb/tb_mv_pwm_driver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mv_pwm_driver.sv
// Purpose : scales and saturates the PID manipulation value into a PWM duty and
//           double-buffers it to period boundaries. Drives the PWM waveform and
//           latches a fault after a run of overflow-flagged samples.
// Latency : sample -> pending 1 edge; pending -> duty at the next wrap.
//           pwm_out_o/period_start_o lag cnt/duty by 1 cycle.
// Backpr. : none; every mv_valid_i strobe is consumed (accepted or discarded) at once.
// Ports   : clk, rst (async, active high)
//           mv_i[31:0] signed MV, of_i[4:0] overflow flags, mv_valid_i sample strobe,
//           fault_clr_i leave-FAULT request
//           pwm_out_o, period_start_o, duty_o[PWM_BITS-1:0] active duty,
//           sat_hi_o / sat_lo_o clip flags of the last accepted sample, fault_o
module mv_pwm_driver #(
  parameter int SHIFT       = 16,
  parameter int PWM_BITS    = 10,
  parameter int FAULT_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         mv_i,
  input  logic [4:0]          of_i,
  input  logic                mv_valid_i,
  input  logic                fault_clr_i,
  output logic                pwm_out_o,
  output logic                period_start_o,
  output logic [PWM_BITS-1:0] duty_o,
  output logic                sat_hi_o,
  output logic                sat_lo_o,
  output logic                fault_o
);

  localparam int MAX = (2 ** PWM_BITS) - 1;
  localparam int BCW = $clog2(FAULT_LIMIT + 1);
  localparam logic [BCW-1:0]      BAD_LIM = BCW'(FAULT_LIMIT);
  localparam logic [PWM_BITS-1:0] CNT_TOP = PWM_BITS'(MAX - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(MAX);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pending_q, pending_d;
  logic                sat_hi_q, sat_hi_d;
  logic                sat_lo_q, sat_lo_d;
  logic [BCW-1:0]      bad_cnt_q, bad_cnt_d;
  logic                pwm_q, pwm_d;
  logic                ps_q, ps_d;
  // Low for the first edge after reset release so the counter holds 0 for one
  // extra cycle; the first period_start pulse then lands on the 2nd edge.
  logic                go_q;

  logic signed [31:0]  scaled;
  logic [PWM_BITS-1:0] sample_dat;
  logic                sample_hi;
  logic                sample_lo;
  logic [BCW-1:0]      bad_inc;
  logic                wrap;

  // Scale and clip the incoming sample.
  always_comb begin
    scaled     = $signed(mv_i) >>> SHIFT;
    sample_dat = scaled[PWM_BITS-1:0];
    sample_hi  = 1'b0;
    sample_lo  = 1'b0;
    if (scaled < 0) begin
      sample_dat = '0;
      sample_lo  = 1'b1;
    end else if (scaled > MAX) begin
      sample_dat = DUTY_MAX;
      sample_hi  = 1'b1;
    end
  end

  assign bad_inc = (bad_cnt_q == BAD_LIM) ? bad_cnt_q : bad_cnt_q + BCW'(1);
  assign wrap    = go_q && (cnt_q == CNT_TOP);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    sat_hi_d  = sat_hi_q;
    sat_lo_d  = sat_lo_q;
    bad_cnt_d = bad_cnt_q;
    cnt_d     = cnt_q;
    duty_d    = duty_q;

    unique case (state_q)
      RUN: begin
        if (mv_valid_i && (of_i == '0)) begin
          pending_d = sample_dat;
          sat_hi_d  = sample_hi;
          sat_lo_d  = sample_lo;
          bad_cnt_d = '0;
        end else if (mv_valid_i) begin
          bad_cnt_d = bad_inc;
          if (bad_inc == BAD_LIM) state_d = FAULT;
        end
        // A trip on the same cycle takes precedence over the clear.
        if (fault_clr_i && (state_d == RUN)) bad_cnt_d = '0;
      end
      FAULT: begin
        if (fault_clr_i) begin
          state_d   = RUN;
          bad_cnt_d = '0;
        end
      end
      default: state_d = RUN;
    endcase

    if (go_q) cnt_d = wrap ? '0 : cnt_q + PWM_BITS'(1);
    // Old pending is loaded on the wrap even if a new sample lands this cycle.
    if (wrap) duty_d = pending_q;

    // Entering or staying in FAULT zeroes the duty path, including on the trip edge.
    if (state_d == FAULT) begin
      pending_d = '0;
      duty_d    = '0;
      sat_hi_d  = 1'b0;
      sat_lo_d  = 1'b0;
    end
  end

  assign pwm_d = (state_q == RUN) && (cnt_q < duty_q);
  assign ps_d  = go_q && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      duty_q    <= '0;
      pending_q <= '0;
      sat_hi_q  <= 1'b0;
      sat_lo_q  <= 1'b0;
      bad_cnt_q <= '0;
      pwm_q     <= 1'b0;
      ps_q      <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      pending_q <= pending_d;
      sat_hi_q  <= sat_hi_d;
      sat_lo_q  <= sat_lo_d;
      bad_cnt_q <= bad_cnt_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
      go_q      <= 1'b1;
    end
  end

  assign pwm_out_o      = pwm_q;
  assign period_start_o = ps_q;
  assign duty_o         = duty_q;
  assign sat_hi_o       = sat_hi_q;
  assign sat_lo_o       = sat_lo_q;
  assign fault_o        = (state_q == FAULT);

endmodule

// File: tb/tb_mv_pwm_driver.sv
// Purpose : directed self-checking bench for mv_pwm_driver (PWM_BITS=4, MAX=15).
// Latency : observes outputs 1 time unit after each rising edge.
// Backpr. : none; inputs are driven right after each observation point.
module tb_mv_pwm_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mv  = '0;
  logic [4:0]  of  = '0;
  logic        vld = 1'b0;
  logic        clr = 1'b0;
  logic        pwm;
  logic        ps;
  logic [3:0]  duty;
  logic        sat_hi;
  logic        sat_lo;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;
  int hi_cnt;
  int ps_cnt;

  always #5 clk = ~clk;

  mv_pwm_driver #(.SHIFT(16), .PWM_BITS(4), .FAULT_LIMIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mv_i           (mv),
    .of_i           (of),
    .mv_valid_i     (vld),
    .fault_clr_i    (clr),
    .pwm_out_o      (pwm),
    .period_start_o (ps),
    .duty_o         (duty),
    .sat_hi_o       (sat_hi),
    .sat_lo_o       (sat_lo),
    .fault_o        (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] v, input logic [4:0] f);
    mv  = v;
    of  = f;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    of  = '0;
  endtask

  // Advance until period_start is seen (counter then sits at 1).
  task automatic wait_ps(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ps === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // One full period of pwm/period_start observations.
  task automatic count_period();
    hi_cnt = 0;
    ps_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (pwm === 1'b1) hi_cnt++;
      if (ps === 1'b1) ps_cnt++;
    end
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #16;
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_ps", 32'(ps), 32'd0);
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_sat", 32'({sat_hi, sat_lo}), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    #3 rst = 1'b0;
    tick();
    chk("ps_edge1", 32'(ps), 32'd0);
    tick();
    chk("ps_edge2", 32'(ps), 32'd1);

    // Mid-range sample, 8/15 duty
    strobe(32'h0008_0000, 5'd0);
    chk("mid_duty_before_wrap", 32'(duty), 32'd0);
    chk("mid_sat", 32'({sat_hi, sat_lo}), 32'd0);
    wait_ps("mid_wait");
    chk("mid_duty", 32'(duty), 32'd8);
    count_period();
    chk("mid_hi_count", 32'(hi_cnt), 32'd8);
    chk("mid_ps_count", 32'(ps_cnt), 32'd1);
    chk("mid_ps_at_period", 32'(ps), 32'd1);

    // Negative clip
    strobe(32'hFFFF_0000, 5'd0);
    chk("neg_sat", 32'({sat_hi, sat_lo}), 32'b01);
    chk("neg_duty_held", 32'(duty), 32'd8);
    wait_ps("neg_wait");
    chk("neg_duty", 32'(duty), 32'd0);
    count_period();
    chk("neg_hi_count", 32'(hi_cnt), 32'd0);

    // Positive clip
    strobe(32'h0100_0000, 5'd0);
    chk("pos_sat", 32'({sat_hi, sat_lo}), 32'b10);
    wait_ps("pos_wait");
    chk("pos_duty", 32'(duty), 32'd15);
    count_period();
    chk("pos_hi_count", 32'(hi_cnt), 32'd15);

    // Overflow-flagged sample is discarded
    strobe(32'h0008_0000, 5'd0);
    wait_ps("of_wait0");
    chk("of_duty8", 32'(duty), 32'd8);
    strobe(32'h0003_0000, 5'b00001);
    chk("of_sat_kept", 32'({sat_hi, sat_lo}), 32'd0);
    wait_ps("of_wait1");
    chk("of_duty_kept", 32'(duty), 32'd8);
    strobe(32'h0003_0000, 5'd0);
    wait_ps("of_wait2");
    chk("clean_duty3", 32'(duty), 32'd3);
    for (int i = 0; i < 3; i++) strobe(32'h0003_0000, 5'b10000);
    chk("bad3_no_fault", 32'(fault), 32'd0);

    // Fault trip after four consecutive bad samples
    strobe(32'h0003_0000, 5'd0);
    for (int i = 0; i < 3; i++) strobe(32'h0003_0000, 5'b00100);
    chk("trip_pre", 32'(fault), 32'd0);
    strobe(32'h0003_0000, 5'b00100);
    chk("trip_fault", 32'(fault), 32'd1);
    chk("trip_duty", 32'(duty), 32'd0);
    tick();
    chk("trip_pwm", 32'(pwm), 32'd0);
    strobe(32'h0100_0000, 5'd0);
    chk("fault_ignore_sat", 32'({sat_hi, sat_lo}), 32'd0);
    count_period();
    chk("fault_hi_count", 32'(hi_cnt), 32'd0);
    chk("fault_ps_count", 32'(ps_cnt), 32'd1);
    chk("fault_held", 32'(fault), 32'd1);
    chk("fault_duty", 32'(duty), 32'd0);
    clr = 1'b1;
    strobe(32'h0100_0000, 5'd0);
    clr = 1'b0;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_sample_ignored", 32'({sat_hi, sat_lo}), 32'd0);
    wait_ps("clr_wait0");
    wait_ps("clr_wait1");
    chk("clr_duty_zero", 32'(duty), 32'd0);

    // Sample landing on the wrap edge (cnt==14)
    strobe(32'h0005_0000, 5'd0);
    for (int i = 0; i < 12; i++) tick();
    strobe(32'h000C_0000, 5'd0);
    chk("wrap_duty_old", 32'(duty), 32'd5);
    tick();
    chk("wrap_ps", 32'(ps), 32'd1);
    wait_ps("wrap_wait");
    chk("wrap_duty_new", 32'(duty), 32'd12);

    // Asynchronous reset mid-period
    tick();
    tick();
    chk("arst_pwm_pre", 32'(pwm), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_pwm", 32'(pwm), 32'd0);
    chk("arst_duty", 32'(duty), 32'd0);
    chk("arst_ps", 32'(ps), 32'd0);
    chk("arst_fault_sat", 32'({fault, sat_hi, sat_lo}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("arst_ps_edge1", 32'(ps), 32'd0);
    tick();
    chk("arst_ps_edge2", 32'(ps), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
